// File: rtl/led_ramp_pwm.sv
// LED brightness ramp with PWM drive: level slews toward the rotary target one step
// per prescaler tick, and decoder error events override the LED with a timed blink.
module led_ramp_pwm #(
  parameter int RAMP_BITS    = 16,
  parameter int FLASH_HALVES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] target,
  input  logic       err_in,
  input  logic       button_n,
  output logic       pwm_out,
  output logic [6:0] level,
  output logic       busy
);

  localparam int FW = $clog2(FLASH_HALVES + 1);

  typedef enum logic [1:0] {IDLE, RAMP, FLASH} state_t;

  state_t               state, state_nxt;
  logic [RAMP_BITS-1:0] presc;
  logic [6:0]           target_level;
  logic [6:0]           phase;
  logic [FW-1:0]        flash_cnt;
  logic                 blink;
  logic                 err_prev;
  logic                 armed;
  logic                 tick;
  logic                 err_evt;
  logic                 pwm_nxt;

  assign tick    = &presc;
  // armed masks the first post-reset cycle so a held err_in level is not an event
  assign err_evt = armed & (err_in ^ err_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc        <= '0;
      phase        <= '0;
      target_level <= '0;
      err_prev     <= 1'b0;
      armed        <= 1'b0;
    end else begin
      presc        <= presc + 1'b1;
      phase        <= phase + 7'd1;
      target_level <= target[6:0];
      err_prev     <= err_in;
      armed        <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (tick) begin
      if (level < target_level)      level <= level + 7'd1;
      else if (level > target_level) level <= level - 7'd1;
    end
  end

  // An error event wins over a coincident tick: reload, no toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_cnt <= '0;
      blink     <= 1'b0;
    end else if (err_evt) begin
      flash_cnt <= FW'(FLASH_HALVES);
      blink     <= 1'b1;
    end else if (state == FLASH && tick) begin
      flash_cnt <= flash_cnt - 1'b1;
      blink     <= ~blink;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (target_level != level) state_nxt = RAMP;
      RAMP:  if (target_level == level) state_nxt = IDLE;
      FLASH: if (tick && flash_cnt == FW'(1))
               state_nxt = (target_level != level) ? RAMP : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (err_evt) state_nxt = FLASH;
  end

  always_comb begin
    busy = (state == RAMP) || (state == FLASH && level != target_level);
    if (state == FLASH)  pwm_nxt = blink;
    else if (!button_n)  pwm_nxt = 1'b1;
    else                 pwm_nxt = (level > phase);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_out <= 1'b0;
    else     pwm_out <= pwm_nxt;
  end

endmodule

// File: doc/led_ramp_pwm.md
LED_RAMP_PWM -- requirements
Module: led_ramp_pwm

Interface
REQ-001 Parameter RAMP_BITS, default 16, sets the ramp prescaler width; one ramp tick occurs every 2^RAMP_BITS clocks.
REQ-002 Parameter FLASH_HALVES, default 4, sets the number of blink half-periods in one error flash.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port target, input, 8 bits: rotary count from the quadrature decoder, synchronous to clk.
REQ-006 Port err_in, input, 1 bit: decoder error toggle; every change of level is one error event.
REQ-007 Port button_n, input, 1 bit: debounced pushbutton, active-low (0 = pressed).
REQ-008 Port pwm_out, output, 1 bit: registered PWM LED drive.
REQ-009 Port level, output, 7 bits: current brightness level.
REQ-010 Port busy, output, 1 bit: high while level differs from the target level.

Function
REQ-011 target_level SHALL be target[6:0], registered once per clk (1-cycle input latency), with no saturation; target 127 -> 128 gives target_level 127 -> 0.
REQ-012 The prescaler SHALL be a free-running RAMP_BITS-bit counter; a tick is the cycle in which it is all-ones, and it wraps to 0.
REQ-013 On a tick, level SHALL move by +1 if level < target_level, by -1 if level > target_level, and hold if they are equal; level never overshoots and never wraps.
REQ-014 Between ticks, level SHALL hold.
REQ-015 phase SHALL be a free-running 7-bit counter, +1 per clk, wrapping 127 -> 0.
REQ-016 The normal PWM value SHALL be (level > phase); level 0 gives constant 0, and level 127 gives 127 of every 128 clocks high.
REQ-017 The state machine SHALL have the states IDLE, RAMP and FLASH.
REQ-018 IDLE -> RAMP when registered target_level != level.
REQ-019 RAMP -> IDLE on the cycle after level == target_level.
REQ-020 Any state -> FLASH on an err_in event; on entry, the flash counter loads FLASH_HALVES and blink loads 1.
REQ-021 In FLASH, each tick SHALL toggle blink and decrement the flash counter; when the counter reaches 0, the state goes to RAMP if level != target_level, else to IDLE.
REQ-022 An err_in event while in FLASH SHALL reload the counter to FLASH_HALVES and blink to 1 (restart, not queued).
REQ-023 Ramping per REQ-013 SHALL continue during FLASH.
REQ-024 err_in events SHALL be detected by comparing err_in with its previous-cycle register.
REQ-025 The first clock after reset deasserts SHALL only load the previous-cycle register and SHALL NOT generate an event.
REQ-026 pwm_out priority, registered (1-cycle latency): FLASH -> blink; else button_n == 0 -> 1; else the normal PWM value.
REQ-027 busy SHALL be 1 exactly when the state is RAMP, or when the state is FLASH with level != target_level.
REQ-028 Simultaneous tick and err_in event SHALL take effect together: the level step applies and FLASH is entered or restarted, with no blink toggle on that tick.

Reset
REQ-029 While rst is high, the block SHALL asynchronously hold level = 0, phase = 0, prescaler = 0, state = IDLE, pwm_out = 0, busy = 0, flash counter = 0, blink = 0, registered target_level = 0.
REQ-030 While rst is high, the previous-cycle err_in register SHALL be 0 and the post-reset arm flag SHALL be cleared.
REQ-031 Reset asserted mid-ramp or mid-flash SHALL abort the operation immediately, with no pending steps retained after release.

Verification
REQ-032 Scenario: RAMP_BITS=4, reset, target=10 held -> busy rises 2 clks after the target change; level reaches 10 after 10 ticks (about 160 clks), then stays there; busy falls the cycle after.
REQ-033 Scenario: level=10, target=3 -> level decrements 10..3, one step per tick, with no undershoot to 2.
REQ-034 Scenario: level=64, button_n=1 -> pwm_out high for exactly 64 of every 128 clks; level=0 -> pwm_out always 0; button_n=0 -> pwm_out constant 1.
REQ-035 Scenario: err_in toggles once, FLASH_HALVES=4 -> pwm_out=1 for the first tick interval, then alternates for 4 tick intervals total, then returns to normal PWM; a second toggle mid-flash restarts the full 4 half-periods.
REQ-036 Scenario: err_in=1 held through reset release -> no FLASH entry; a later 1 -> 0 change -> FLASH entered.
REQ-037 Scenario: rst pulsed mid-ramp at level=5 -> level=0, state IDLE, pwm_out=0 asynchronously; the ramp restarts from 0 after release.
